// File: rtl/rca_seq_adder_if.sv
// rca_seq_adder_if: operand/result handshake bundle for rca_seq_adder.
//   in_valid/in_ready  : operation request handshake
//   inp1, inp2         : operands A and B (WIDTH bits)
//   cin                : carry-in (add) / borrow-in (sub)
//   sub                : 0 = A+B+cin, 1 = A-B-cin
//   out_valid/out_ready: result handshake
//   sum, cout, ovf     : result, carry-out (NOT borrow-out on sub), signed overflow
// master drives the request side, slave is the adder.
`timescale 1ns / 1ps
interface rca_seq_adder_if #(
  parameter int unsigned WIDTH = 24
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] inp1;
  logic [WIDTH-1:0] inp2;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, inp1, inp2, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, inp1, inp2, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/rca_seq_adder.sv
// rca_seq_adder: multi-cycle ripple-carry adder/subtractor.
// Latches WIDTH-bit operands, then adds CHUNK bits per clock (LSB slice first) with the
// inter-slice carry held in a register. Result appears NSEG = WIDTH/CHUNK cycles after accept.
// Ports:
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : rca_seq_adder_if slave (request/result handshakes, operands, result flags)
`timescale 1ns / 1ps
module rca_seq_adder #(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned CHUNK = 8
) (
  input logic            clk,
  input logic            rst,
  rca_seq_adder_if.slave bus
);

  localparam int unsigned NSEG = WIDTH / CHUNK;
  localparam int unsigned CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;      // already inverted for subtract
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] a_slice, b_slice;
  logic [CHUNK:0]   seg_sum;
  logic [WIDTH-1:0] res_ins;
  logic             last_seg;

  always_comb begin
    a_slice  = a_q[cnt_q*CHUNK +: CHUNK];
    b_slice  = b_q[cnt_q*CHUNK +: CHUNK];
    seg_sum  = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
    res_ins  = res_q;
    res_ins[cnt_q*CHUNK +: CHUNK] = seg_sum[CHUNK-1:0];
    last_seg = (cnt_q == CW'(NSEG - 1));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.inp1;
          b_d     = bus.sub ? ~bus.inp2 : bus.inp2;
          // Subtract as A + ~B + 1 - borrow, so the initial carry is cin ^ sub.
          carry_d = bus.cin ^ bus.sub;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        res_d   = res_ins;
        carry_d = seg_sum[CHUNK];
        if (last_seg) begin
          sum_d   = res_ins;
          cout_d  = seg_sum[CHUNK];
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_ins[WIDTH-1] != a_q[WIDTH-1]);
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_rca_seq_adder.sv
// tb_rca_seq_adder: self-checking bench for rca_seq_adder.
// Three instances: 24/8 (NSEG=3), 24/24 (NSEG=1), 32/4 (NSEG=8), checked against an
// arithmetic reference model.
`timescale 1ns / 1ps
module tb_rca_seq_adder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rca_seq_adder_if #(.WIDTH(24)) if0 ();
  rca_seq_adder_if #(.WIDTH(24)) if1 ();
  rca_seq_adder_if #(.WIDTH(32)) if2 ();

  rca_seq_adder #(.WIDTH(24), .CHUNK(8))  u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  rca_seq_adder #(.WIDTH(24), .CHUNK(24)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));
  rca_seq_adder #(.WIDTH(32), .CHUNK(4))  u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  int wid [3]  = '{24, 24, 32};
  int nseg [3] = '{3, 1, 8};

  logic [31:0] drv_a [3];
  logic [31:0] drv_b [3];
  logic        drv_valid [3];
  logic        drv_cin [3];
  logic        drv_sub [3];
  logic        drv_ordy [3];

  logic [31:0] mon_sum [3];
  logic        mon_cout [3];
  logic        mon_ovf [3];
  logic        mon_ready [3];
  logic        mon_valid [3];

  assign if0.in_valid  = drv_valid[0];
  assign if0.inp1      = drv_a[0][23:0];
  assign if0.inp2      = drv_b[0][23:0];
  assign if0.cin       = drv_cin[0];
  assign if0.sub       = drv_sub[0];
  assign if0.out_ready = drv_ordy[0];
  assign if1.in_valid  = drv_valid[1];
  assign if1.inp1      = drv_a[1][23:0];
  assign if1.inp2      = drv_b[1][23:0];
  assign if1.cin       = drv_cin[1];
  assign if1.sub       = drv_sub[1];
  assign if1.out_ready = drv_ordy[1];
  assign if2.in_valid  = drv_valid[2];
  assign if2.inp1      = drv_a[2];
  assign if2.inp2      = drv_b[2];
  assign if2.cin       = drv_cin[2];
  assign if2.sub       = drv_sub[2];
  assign if2.out_ready = drv_ordy[2];

  assign mon_sum[0]   = {8'd0, if0.sum};
  assign mon_sum[1]   = {8'd0, if1.sum};
  assign mon_sum[2]   = if2.sum;
  assign mon_cout[0]  = if0.cout;
  assign mon_cout[1]  = if1.cout;
  assign mon_cout[2]  = if2.cout;
  assign mon_ovf[0]   = if0.ovf;
  assign mon_ovf[1]   = if1.ovf;
  assign mon_ovf[2]   = if2.ovf;
  assign mon_ready[0] = if0.in_ready;
  assign mon_ready[1] = if1.in_ready;
  assign mon_ready[2] = if2.in_ready;
  assign mon_valid[0] = if0.out_valid;
  assign mon_valid[1] = if1.out_valid;
  assign mon_valid[2] = if2.out_valid;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular/signed integer arithmetic on the operation A +/- B +/- cin.
  function automatic void ref_model(input int w, input logic [31:0] a, input logic [31:0] b,
                                    input logic c, input logic s, output logic [31:0] rs,
                                    output logic rc, output logic ro);
    longint full, half, ua, ub, uc, t, sa, sb, sv;
    full = longint'(1) << w;
    half = full / 2;
    ua   = longint'({32'd0, a});
    ub   = longint'({32'd0, b});
    uc   = longint'({63'd0, c});
    t    = s ? (ua - ub - uc) : (ua + ub + uc);
    rs   = 32'(t & (full - 1));
    rc   = s ? (t >= 0) : (t >= full);
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    sv   = s ? (sa - sb - uc) : (sa + sb + uc);
    ro   = (sv >= half) || (sv < -half);
  endfunction

  function automatic logic [31:0] wmask(input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return 32'(m);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operation and return just after the acceptance edge; inputs are then scrambled.
  task automatic start_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic c, input logic s);
    int n;
    drv_a[i] = a; drv_b[i] = b; drv_cin[i] = c; drv_sub[i] = s; drv_valid[i] = 1'b1;
    n = 0;
    while (!mon_ready[i] && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) check("accept_timeout", 32'(n), 32'd0);
    tick();
    drv_valid[i] = 1'b0;
    drv_a[i] = $urandom; drv_b[i] = $urandom;
    drv_cin[i] = 1'($urandom); drv_sub[i] = 1'($urandom);
  endtask

  task automatic wait_done(input int i, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!mon_valid[i] && lat < 100);
  endtask

  task automatic check_result(input int i, input string tag, input logic [31:0] a,
                              input logic [31:0] b, input logic c, input logic s);
    logic [31:0] es;
    logic ec, eo;
    ref_model(wid[i], a, b, c, s, es, ec, eo);
    check({tag, "_sum"}, mon_sum[i], es);
    check({tag, "_cout"}, 32'(mon_cout[i]), 32'(ec));
    check({tag, "_ovf"}, 32'(mon_ovf[i]), 32'(eo));
  endtask

  task automatic finish_op(input int i, input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic c, input logic s);
    int lat;
    wait_done(i, lat);
    check({tag, "_latency"}, 32'(lat), 32'(nseg[i]));
    check_result(i, tag, a, b, c, s);
    drv_ordy[i] = 1'b1;
    tick();
    drv_ordy[i] = 1'b0;
    check({tag, "_release"}, {30'd0, mon_valid[i], mon_ready[i]}, 32'd1);
  endtask

  task automatic do_op(input int i, input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic c, input logic s);
    start_op(i, a, b, c, s);
    finish_op(i, tag, a, b, c, s);
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = wmask(w);
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return m;
      2:       return m >> 1;
      3:       return (m >> 1) + 32'd1;
      default: return $urandom & m;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] es, ra, rb;
    logic ec, eo, seen, rc, rs;
    int lat;
    for (int i = 0; i < 3; i++) begin
      drv_a[i] = '0; drv_b[i] = '0; drv_valid[i] = 1'b0;
      drv_cin[i] = 1'b0; drv_sub[i] = 1'b0; drv_ordy[i] = 1'b0;
    end
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_in_ready", 32'(mon_ready[0]), 32'd1);
    check("rst_out_valid", 32'(mon_valid[0]), 32'd0);
    check("rst_sum", mon_sum[0], 32'd0);
    check("rst_flags", {30'd0, mon_cout[0], mon_ovf[0]}, 32'd0);

    // Directed vectors, 24/8.
    do_op(0, "slice_carry", 32'h00FFFF, 32'h000001, 1'b0, 1'b0);
    do_op(0, "full_cout", 32'hFFFFFF, 32'h000001, 1'b0, 1'b0);
    do_op(0, "pos_ovf", 32'h7FFFFF, 32'h000001, 1'b0, 1'b0);
    do_op(0, "sub_neg", 32'h000005, 32'h000007, 1'b0, 1'b1);
    do_op(0, "sub_borrow", 32'h000005, 32'h000007, 1'b1, 1'b1);
    do_op(0, "sub_ovf", 32'h800000, 32'h000001, 1'b0, 1'b1);
    check("const_sub_borrow", mon_sum[0], 32'h7FFFFF);

    // Backpressure with a second operation waiting on in_valid.
    start_op(0, 32'h00A5A5, 32'h005A5B, 1'b1, 1'b0);
    wait_done(0, lat);
    check("bp_latency", 32'(lat), 32'd3);
    ref_model(24, 32'h00A5A5, 32'h005A5B, 1'b1, 1'b0, es, ec, eo);
    drv_a[0] = 32'h123000; drv_b[0] = 32'h000456; drv_cin[0] = 1'b0; drv_sub[0] = 1'b1;
    drv_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", {30'd0, mon_valid[0], mon_ready[0]}, 32'd2);
      check("bp_hold_sum", mon_sum[0], es);
      check("bp_hold_flags", {30'd0, mon_cout[0], mon_ovf[0]}, {30'd0, ec, eo});
      tick();
    end
    drv_ordy[0] = 1'b1;
    tick();
    drv_ordy[0] = 1'b0;
    check("bp_idle_again", {30'd0, mon_valid[0], mon_ready[0]}, 32'd1);
    tick();
    check("bp_second_accepted", 32'(mon_ready[0]), 32'd0);
    drv_valid[0] = 1'b0;
    finish_op(0, "bp_second", 32'h123000, 32'h000456, 1'b0, 1'b1);

    // Reset while the counter is 1.
    start_op(0, 32'h0F0F0F, 32'h010101, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 32'(mon_ready[0]), 32'd1);
    check("midrst_sum", mon_sum[0], 32'd0);
    check("midrst_flags", {30'd0, mon_cout[0], mon_ovf[0]}, 32'd0);
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      seen |= mon_valid[0];
      tick();
    end
    check("midrst_no_valid", 32'(seen), 32'd0);
    do_op(0, "post_rst", 32'h123456, 32'h654321, 1'b0, 1'b0);
    check("const_post_rst", mon_sum[0], 32'h777777);

    // NSEG = 1 corner.
    do_op(1, "n1_cout", 32'hFFFFFF, 32'h000001, 1'b0, 1'b0);
    do_op(1, "n1_sub", 32'h800000, 32'h000001, 1'b0, 1'b1);

    // Random vectors on all three configurations.
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 25; n++) begin
        ra = pick(wid[i]);
        rb = pick(wid[i]);
        rc = 1'($urandom);
        rs = 1'($urandom);
        do_op(i, $sformatf("rnd%0d_%0d", i, n), ra, rb, rc, rs);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
